// File: rtl/conv_layer_scheduler.sv
// Sequences one shared convolution unit over every (filter, row, column) window
// of a layer: launch the unit, wait for it, and store its result.
module conv_layer_scheduler #(
    parameter int unsigned H       = 32,
    parameter int unsigned W       = 32,
    parameter int unsigned F       = 5,
    parameter int unsigned K       = 6,
    parameter int unsigned P       = 0,
    parameter int unsigned TIMEOUT = 1024,
    localparam int unsigned OH = H - F + 1 + 2 * P,
    localparam int unsigned OW = W - F + 1 + 2 * P,
    localparam int unsigned N  = K * OH * OW,
    localparam int unsigned RW = (OH > 1) ? $clog2(OH) : 1,
    localparam int unsigned CW = (OW > 1) ? $clog2(OW) : 1,
    localparam int unsigned KW = (K > 1) ? $clog2(K) : 1,
    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          conv_done,
    output logic          conv_start,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic [KW-1:0] filter_idx,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] tmo_cnt;
    logic          idx_clr;
    logic          idx_adv;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          err_set;
    logic          last_win;

    assign last_win = (filter_idx == KW'(K - 1)) &&
                      (win_row == RW'(OH - 1)) &&
                      (win_col == CW'(OW - 1));

    // State register; reset abandons any pass in progress.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_next = state;
        idx_clr    = 1'b0;
        idx_adv    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    idx_clr    = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cnt_clr    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (conv_done) begin
                    state_next = WRITE;
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WRITE: begin
                if (last_win) begin
                    state_next = FIN;
                end else begin
                    idx_adv    = 1'b1;
                    state_next = ISSUE;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control outputs registered so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!reset) begin
            conv_start <= 1'b0;
            wr_en      <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            conv_start <= (state_next == ISSUE);
            wr_en      <= (state_next == WRITE);
            done       <= (state_next == FIN);
            busy       <= (state_next != IDLE);
        end
    end

    // Window indices: column fastest, then row, then filter.
    always_ff @(posedge clk) begin
        if (!reset || idx_clr) begin
            win_col    <= '0;
            win_row    <= '0;
            filter_idx <= '0;
        end else if (idx_adv) begin
            if (win_col == CW'(OW - 1)) begin
                win_col <= '0;
                if (win_row == RW'(OH - 1)) begin
                    win_row    <= '0;
                    filter_idx <= filter_idx + KW'(1);
                end else begin
                    win_row <= win_row + RW'(1);
                end
            end else begin
                win_col <= win_col + CW'(1);
            end
        end
    end

    // Result address tracks the registered indices; stable well before WRITE.
    always_ff @(posedge clk) begin
        if (!reset) wr_addr <= '0;
        else        wr_addr <= AW'(32'(filter_idx) * OH * OW + 32'(win_row) * OW + 32'(win_col));
    end

    // Per-window WAIT cycle counter.
    always_ff @(posedge clk) begin
        if (!reset || cnt_clr) tmo_cnt <= '0;
        else if (cnt_inc)      tmo_cnt <= tmo_cnt + TW'(1);
    end

    // Sticky timeout flag, cleared when a new pass is accepted.
    always_ff @(posedge clk) begin
        if (!reset || idx_clr) err <= 1'b0;
        else if (err_set)      err <= 1'b1;
    end

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench: small 2x2x2 layer (A), padded 4x4x1 layer (B), default 28x28x6 layer (C).
module tb_conv_layer_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- instance A: H=W=6 F=5 K=2 P=0 TIMEOUT=16 ----------------
    logic       a_reset, a_start, a_conv_done, a_conv_start, a_wr_en, a_busy, a_done, a_err;
    logic [0:0] a_row, a_col, a_filter;
    logic [2:0] a_wr_addr;
    logic       a_resp = 1'b0, a_noise = 1'b0, a_raw = 1'b0, a_noise_mode = 1'b0;
    assign a_conv_done = a_resp | a_noise | a_raw;

    conv_layer_scheduler #(.H(6), .W(6), .F(5), .K(2), .P(0), .TIMEOUT(16)) dut_a (
        .clk(clk), .reset(a_reset), .start(a_start), .conv_done(a_conv_done),
        .conv_start(a_conv_start), .win_row(a_row), .win_col(a_col), .filter_idx(a_filter),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .busy(a_busy), .done(a_done), .err(a_err));

    int a_delay = 1, a_hold = -1;
    int a_cyc = 0, a_win = 0, a_wcnt = 0, a_pw = 0, a_nwr = 0, a_ndone = 0, a_bad = 0;
    int a_hold_cyc = 0, a_last_addr = -1, a_done_cyc = 0, a_gap = -1;
    bit a_prev_busy = 1'b0, a_inwait = 1'b0, a_gap_arm = 1'b0;

    // A: unit responder and write/done monitor
    initial begin
        forever begin
            @(negedge clk);
            a_cyc++;
            a_inwait = a_busy && !a_conv_start && !a_wr_en && !a_done;
            if (a_busy && !a_prev_busy) begin a_win = 0; a_pw = 0; end
            a_prev_busy = a_busy;
            if (a_conv_start) a_win++;
            a_wcnt = a_inwait ? a_wcnt + 1 : 0;
            if (a_inwait && (a_win - 1) == a_hold) a_hold_cyc = a_wcnt;
            a_resp  = a_inwait && (a_wcnt == a_delay) && ((a_win - 1) != a_hold);
            a_noise = a_noise_mode && !a_inwait;
            if (a_wr_en) begin
                if (int'(a_wr_addr) != a_pw || int'(a_filter) != a_pw / 4 ||
                    int'(a_row) != (a_pw % 4) / 2 || int'(a_col) != a_pw % 2) a_bad++;
                a_last_addr = int'(a_wr_addr);
                a_pw++;
                a_nwr++;
            end
            if (a_done) begin
                a_ndone++; a_done_cyc = a_cyc; a_gap_arm = 1'b1;
            end else if (a_conv_start && a_gap_arm) begin
                a_gap = a_cyc - a_done_cyc; a_gap_arm = 1'b0;
            end
        end
    end

    // ---------------- instance B: H=W=6 F=5 K=1 P=1 ----------------
    logic       bc_reset, b_start, b_conv_start, b_wr_en, b_busy, b_done, b_err;
    logic [1:0] b_row, b_col;
    logic [0:0] b_filter;
    logic [3:0] b_wr_addr;
    logic       b_resp = 1'b0;

    conv_layer_scheduler #(.H(6), .W(6), .F(5), .K(1), .P(1)) dut_b (
        .clk(clk), .reset(bc_reset), .start(b_start), .conv_done(b_resp),
        .conv_start(b_conv_start), .win_row(b_row), .win_col(b_col), .filter_idx(b_filter),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .busy(b_busy), .done(b_done), .err(b_err));

    int b_wcnt = 0, b_pw = 0, b_nwr = 0, b_ndone = 0, b_bad = 0, b_maxr = 0, b_maxc = 0;
    bit b_prev_busy = 1'b0, b_inwait = 1'b0;

    // B: one-cycle responder and monitor
    initial begin
        forever begin
            @(negedge clk);
            b_inwait = b_busy && !b_conv_start && !b_wr_en && !b_done;
            if (b_busy && !b_prev_busy) b_pw = 0;
            b_prev_busy = b_busy;
            b_wcnt = b_inwait ? b_wcnt + 1 : 0;
            b_resp = b_inwait && (b_wcnt == 1);
            if (b_wr_en) begin
                if (int'(b_wr_addr) != b_pw || int'(b_filter) != 0 ||
                    int'(b_row) != b_pw / 4 || int'(b_col) != b_pw % 4) b_bad++;
                if (int'(b_row) > b_maxr) b_maxr = int'(b_row);
                if (int'(b_col) > b_maxc) b_maxc = int'(b_col);
                b_pw++;
                b_nwr++;
            end
            if (b_done) b_ndone++;
        end
    end

    // ---------------- instance C: defaults (OH=OW=28, K=6, N=4704) ----------------
    logic        c_start, c_conv_start, c_wr_en, c_busy, c_done, c_err;
    logic [4:0]  c_row, c_col;
    logic [2:0]  c_filter;
    logic [12:0] c_wr_addr;
    logic        c_resp = 1'b0;

    conv_layer_scheduler dut_c (
        .clk(clk), .reset(bc_reset), .start(c_start), .conv_done(c_resp),
        .conv_start(c_conv_start), .win_row(c_row), .win_col(c_col), .filter_idx(c_filter),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .busy(c_busy), .done(c_done), .err(c_err));

    int c_delay = 1, c_wcnt = 0, c_pw = 0, c_nwr = 0, c_ndone = 0, c_bad = 0, c_noninc = 0;
    int c_prev_addr = -1, c_rec784 = 0;
    bit c_prev_busy = 1'b0, c_inwait = 1'b0;

    // C: variable-latency responder (1-20 cycles, mostly short) and monitor
    initial begin
        forever begin
            @(negedge clk);
            c_inwait = c_busy && !c_conv_start && !c_wr_en && !c_done;
            if (c_busy && !c_prev_busy) c_pw = 0;
            c_prev_busy = c_busy;
            if (c_conv_start)
                c_delay = ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 20))
                                                      : int'($urandom_range(1, 4));
            c_wcnt = c_inwait ? c_wcnt + 1 : 0;
            c_resp = c_inwait && (c_wcnt == c_delay);
            if (c_wr_en) begin
                if (int'(c_wr_addr) != c_pw || int'(c_filter) != c_pw / 784 ||
                    int'(c_row) != (c_pw % 784) / 28 || int'(c_col) != c_pw % 28) c_bad++;
                if (int'(c_wr_addr) <= c_prev_addr) c_noninc++;
                c_prev_addr = int'(c_wr_addr);
                if (int'(c_wr_addr) == 784)
                    c_rec784 = (c_filter == 3'd1 && c_row == 5'd0 && c_col == 5'd0) ? 1 : 2;
                c_pw++;
                c_nwr++;
            end
            if (c_done) c_ndone++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start on A and wait (bounded) for done or err.
    task automatic run_a(output int cyc, output bit seen, output logic e1);
        @(negedge clk);
        a_start = 1'b1;
        cyc = 0; seen = 1'b0; e1 = 1'bx;
        while (!seen && cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin a_start = 1'b0; e1 = a_err; end
            if (a_done || a_err) seen = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    int  cyc, base_w, base_d, g;
    bit  seen;
    logic e1;

    initial begin
        a_reset = 1'b0; bc_reset = 1'b0;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_conv_start", 32'(a_conv_start), 0);
        check("rst_wr_en",      32'(a_wr_en),      0);
        check("rst_done",       32'(a_done),       0);
        check("rst_busy",       32'(a_busy),       0);
        check("rst_err",        32'(a_err),        0);
        check("rst_filter",     32'(a_filter),     0);
        check("rst_row",        32'(a_row),        0);
        check("rst_col",        32'(a_col),        0);
        check("rst_wr_addr",    32'(a_wr_addr),    0);
        @(negedge clk);
        a_reset = 1'b1; bc_reset = 1'b1;

        // Basic pass, one-cycle unit latency: 8 writes, done 3N+1 = 25 edges incl. the start edge
        base_w = a_nwr; base_d = a_ndone;
        run_a(cyc, seen, e1);
        check("p1_finished",  32'(seen), 1);
        check("p1_done_lat",  cyc, 25);
        check("p1_writes",    a_nwr - base_w, 8);
        check("p1_dones",     a_ndone - base_d, 1);
        check("p1_addr_seq",  a_bad, 0);
        check("p1_last_addr", a_last_addr, 7);
        check("p1_err",       32'(a_err), 0);

        // Timeout on window 3: 16 WAIT cycles, err, no further writes, no done
        a_hold = 3;
        base_w = a_nwr; base_d = a_ndone;
        run_a(cyc, seen, e1);
        check("to_finished",  32'(seen), 1);
        check("to_err",       32'(a_err), 1);
        check("to_busy",      32'(a_busy), 0);
        check("to_writes",    a_nwr - base_w, 3);
        check("to_dones",     a_ndone - base_d, 0);
        check("to_wait_cyc",  a_hold_cyc, 16);

        // Restart clears err and begins again at address 0
        a_hold = -1;
        base_w = a_nwr; base_d = a_ndone;
        run_a(cyc, seen, e1);
        check("rs_err_clear", 32'(e1), 0);
        check("rs_writes",    a_nwr - base_w, 8);
        check("rs_dones",     a_ndone - base_d, 1);
        check("rs_addr_seq",  a_bad, 0);

        // Reset during WAIT of window 5, then a stray conv_done
        a_hold = 5;
        base_w = a_nwr; base_d = a_ndone;
        @(negedge clk); a_start = 1'b1;
        @(posedge clk); #1; a_start = 1'b0;
        g = 0;
        while (!(a_win == 6 && a_wcnt >= 3) && g < 200) begin @(posedge clk); #1; g++; end
        check("mr_reached", 32'(a_win == 6 && a_wcnt >= 3), 1);
        @(negedge clk); a_reset = 1'b0;
        @(posedge clk); #1;
        check("mr_conv_start", 32'(a_conv_start), 0);
        check("mr_wr_en",      32'(a_wr_en),      0);
        check("mr_done",       32'(a_done),       0);
        check("mr_busy",       32'(a_busy),       0);
        check("mr_err",        32'(a_err),        0);
        check("mr_filter",     32'(a_filter),     0);
        check("mr_row",        32'(a_row),        0);
        check("mr_col",        32'(a_col),        0);
        check("mr_wr_addr",    32'(a_wr_addr),    0);
        @(negedge clk); a_reset = 1'b1; a_raw = 1'b1;
        repeat (3) @(negedge clk);
        a_raw = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mr_writes",  a_nwr - base_w, 5);
        check("mr_dones",   a_ndone - base_d, 0);
        check("mr_idle",    32'(a_busy), 0);
        a_hold = -1;

        // start held high, conv_done asserted whenever not in WAIT: two full passes
        a_noise_mode = 1'b1; a_delay = 2;
        base_w = a_nwr; base_d = a_ndone;
        @(negedge clk); a_start = 1'b1;
        g = 0;
        while ((a_ndone - base_d) < 2 && g < 500) begin @(posedge clk); #1; g++; end
        a_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a_noise_mode = 1'b0; a_delay = 1;
        check("bb_writes",   a_nwr - base_w, 16);
        check("bb_dones",    a_ndone - base_d, 2);
        check("bb_addr_seq", a_bad, 0);
        check("bb_gap",      a_gap, 2);
        check("bb_idle",     32'(a_busy), 0);

        // Padded layer: OH=OW=4, 16 writes covering rows/cols 0..3
        @(negedge clk); b_start = 1'b1;
        @(posedge clk); #1; b_start = 1'b0;
        g = 0;
        while (b_ndone == 0 && g < 300) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
        check("pad_done",   b_ndone, 1);
        check("pad_writes", b_nwr, 16);
        check("pad_seq",    b_bad, 0);
        check("pad_maxrow", b_maxr, 3);
        check("pad_maxcol", b_maxc, 3);
        check("pad_err",    32'(b_err), 0);

        // Default layer with variable unit latency
        @(negedge clk); c_start = 1'b1;
        @(posedge clk); #1; c_start = 1'b0;
        g = 0;
        while (c_ndone == 0 && g < 90000) begin @(posedge clk); #1; g++; end
        repeat (3) @(posedge clk);
        #1;
        check("def_done",    c_ndone, 1);
        check("def_writes",  c_nwr, 4704);
        check("def_seq",     c_bad, 0);
        check("def_incr",    c_noninc, 0);
        check("def_rec784",  c_rec784, 1);
        check("def_last",    c_prev_addr, 4703);
        check("def_err",     32'(c_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_layer_scheduler.md
CONV_LAYER_SCHEDULER -- requirements
Module: conv_layer_scheduler

Interface
REQ-001 Parameter H, default 32: input image height in pixels.
REQ-002 Parameter W, default 32: input image width in pixels.
REQ-003 Parameter F, default 5: filter size.
REQ-004 Parameter K, default 6: number of filters.
REQ-005 Parameter P, default 0: padding pixels.
REQ-006 Parameter TIMEOUT, default 1024: maximum WAIT cycles per window.
REQ-007 Derived constants: OH = H-F+1+2P, OW = W-F+1+2P, N = K*OH*OW; RW = max(1,clog2(OH)), CW = max(1,clog2(OW)), KW = max(1,clog2(K)), AW = max(1,clog2(N)).
REQ-008 clk  in  1  single clock; all state updates on the rising edge.
REQ-009 reset  in  1  synchronous, active-low reset.
REQ-010 start  in  1  level; sampled only in IDLE to begin one full layer pass.
REQ-011 conv_done  in  1  shared convolution unit has finished the current window.
REQ-012 conv_start  out  1  one-cycle pulse that launches the shared unit on the current window.
REQ-013 win_row  out  RW  output row of the current window, in padded coordinates.
REQ-014 win_col  out  CW  output column of the current window.
REQ-015 filter_idx  out  KW  filter selected for the current window.
REQ-016 wr_en  out  1  one-cycle pulse that stores the unit result.
REQ-017 wr_addr  out  AW  result address: filter_idx*OH*OW + win_row*OW + win_col.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse at successful completion of a pass.
REQ-020 err  out  1  sticky timeout flag; cleared on the next accepted start or on reset.

Function
REQ-021 The FSM SHALL have five states: IDLE, ISSUE, WAIT, WRITE and FIN.
REQ-022 IDLE: on start=1, clear filter_idx, win_row, win_col and err, then go to ISSUE; otherwise stay in IDLE.
REQ-023 ISSUE lasts exactly one cycle: conv_start=1, then go to WAIT with the timeout counter cleared.
REQ-024 WAIT: on conv_done=1, go to WRITE; otherwise increment the timeout counter each cycle.
REQ-025 WAIT timeout: when the counter reaches TIMEOUT-1 without conv_done, set err=1 and go to IDLE without asserting wr_en or done.
REQ-026 WRITE lasts exactly one cycle: wr_en=1 with wr_addr and the indices of the window just computed.
REQ-027 Leaving WRITE: if the window was the last one (filter K-1, row OH-1, column OW-1), go to FIN; otherwise advance the indices and go to ISSUE.
REQ-028 Index advance order is column, then row, then filter.
- win_col wraps from OW-1 to 0 and increments win_row.
- win_row wraps from OH-1 to 0 and increments filter_idx.
REQ-029 FIN lasts one cycle: done=1, then go to IDLE; the indices hold their final values.
REQ-030 conv_done SHALL be ignored in every state except WAIT, including the ISSUE cycle.
REQ-031 start SHALL be ignored while busy=1; start held high in the FIN cycle does not trigger a pass, and a new pass starts no earlier than the first IDLE cycle.
REQ-032 wr_addr SHALL be computed from registered indices; no result is lost and no address is skipped.
REQ-033 With conv_done returned on the first WAIT cycle, one window takes 3 cycles and a pass takes 3N+1 cycles from the start sample to done.

Reset
REQ-034 When reset=0 at a clock edge, in any state including mid-pass, the FSM SHALL go to IDLE.
REQ-035 Reset values: conv_start=0, wr_en=0, done=0, busy=0, err=0, and filter_idx, win_row, win_col, wr_addr and the timeout counter all 0.
REQ-036 An interrupted pass SHALL NOT resume; a new start is required.

Verification
REQ-037 H=W=6, F=5, K=2, P=0, conv_done one cycle after each conv_start -> 8 wr_en pulses at addresses 0..7, done 25 cycles after the start sample, err=0.
REQ-038 Defaults, variable conv_done delay of 1-20 cycles -> 4704 writes, addresses 0..4703 strictly increasing, the write at address 784 carries filter_idx=1 with row 0 and column 0, done asserted once.
REQ-039 conv_done withheld on window 3, TIMEOUT=16 -> err=1 after 16 WAIT cycles, return to IDLE, no done; the next start clears err and restarts at address 0.
REQ-040 reset=0 asserted during the WAIT of window 5 -> all outputs at reset values the next cycle, and a conv_done pulse afterwards causes no write.
REQ-041 start held high continuously and conv_done pulsed in IDLE, ISSUE and WRITE -> no extra writes, and back-to-back passes each produce the full address sequence.
REQ-042 P=1, H=W=6, F=5, K=1 -> OH=OW=4, 16 writes, win_row and win_col covering 0..3.
